// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
// Define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] quot, rem, dsor, ma, mb, sub, quot_n, rem_n, q_fin, r_fin, fast_res;
  logic [WIDTH:0] sh;
  logic [CW-1:0] cnt;
  logic q_neg, r_neg, rem_op, sgn, is_rem, sa, sb, zero_div, ovf, early, fast, accept, ge;
  assign sgn = ~funct3[0];
  assign is_rem = funct3[1];
  assign sa = sgn & dividend[WIDTH-1];
  assign sb = sgn & divisor[WIDTH-1];
  assign ma = sa ? -dividend : dividend;
  assign mb = sb ? -divisor : divisor;
  assign zero_div = divisor == '0;
  assign ovf = sgn && dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
`ifdef DIV_EARLY_OUT_EN
  assign early = !zero_div && ma < mb;
`else
  assign early = 1'b0;
`endif
  assign fast = zero_div | ovf | early;
  assign fast_res = is_rem ? (ovf ? '0 : dividend) : (zero_div ? '1 : ovf ? dividend : '0);
  assign accept = state == IDLE && start && !flush;
  // One restoring step; the shifted remainder carries an extra bit so the compare cannot wrap.
  assign sh = {rem, quot[WIDTH-1]};
  assign ge = sh >= {1'b0, dsor};
  assign sub = sh[WIDTH-1:0] - dsor;
  assign rem_n = ge ? sub : sh[WIDTH-1:0];
  assign quot_n = {quot[WIDTH-2:0], ge};
  assign q_fin = q_neg ? -quot_n : quot_n;
  assign r_fin = r_neg ? -rem_n : rem_n;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = flush ? IDLE :
              state == IDLE ? (accept ? (fast ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == '0 ? DONE : CALC) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      quot <= '0;
      rem <= '0;
      dsor <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rem_op <= 1'b0;
      result <= '0;
    end else if (accept) begin
      quot <= ma;
      rem <= '0;
      dsor <= mb;
      cnt <= CW'(WIDTH - 1);
      q_neg <= sa ^ sb;
      r_neg <= sa;
      rem_op <= is_rem;
      if (fast) result <= fast_res;
    end else if (state == CALC && !flush) begin
      quot <= quot_n;
      rem <= rem_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) result <= rem_op ? r_fin : q_fin;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized scoreboard bench for div_unit against an arithmetic reference model.
module tb_div_unit;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0] funct3 = 3'b100;
  logic [31:0] dividend = 0, divisor = 0;
  logic busy, done;
  logic [31:0] result, last;
  int cyc = 0, n_cmp = 0, n_err = 0;
  typedef struct {logic [31:0] res; int c0; int lat;} exp_t;
  exp_t sb[$];

  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .dividend(dividend), .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint mag(input logic s, input logic [31:0] x);
    longint v;
    v = s ? longint'($signed(x)) : longint'(x);
    return v < 0 ? -v : v;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic s, r;
    s = !f[0];
    r = f[1];
    if (b == 0) return r ? a : 32'hFFFFFFFF;
    if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return r ? 32'h0 : a;
    if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return r ? a % b : a / b;
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = !f[0];
    if (b == 0 || (s && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 0;
    if (EARLY && mag(s, a) < mag(s, b)) return 0;
    return 32;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && !done && cyc >= sb[0].c0) begin
        n_cmp++;
        if (!busy) begin
          n_err++;
          $display("FAIL busy_in_flight: busy=0 at cycle %0d (start edge %0d)", cyc, sb[0].c0);
        end
      end
      if (done) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: result %h at cycle %0d", result, cyc);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || cyc != e.c0 + e.lat) begin
            n_err++;
            $display("FAIL result: got %h after %0d cycles, expected %h after %0d", result, cyc - e.c0, e.res, e.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy still %b", busy);
    end
    start = 1;
    funct3 = f;
    dividend = a;
    divisor = b;
    e.res = exp;
    e.c0 = cyc + 1;
    e.lat = latency(f, a, b);
    sb.push_back(e);
    last = exp;
    @(negedge clk);
    start = 0;
  endtask

  task automatic finish_op();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
    check("result_hold", result, last);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    issue(f, a, b, exp);
    finish_op();
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0] f;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", result, 0);
    run(3'b101, 100, 7, 32'h0000000E);
    run(3'b111, 100, 7, 32'h00000002);
    run(3'b100, 32'hFFFFFFF9, 2, 32'hFFFFFFFD);
    run(3'b110, 32'hFFFFFFF9, 2, 32'hFFFFFFFF);
    run(3'b100, 7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    run(3'b110, 7, 32'hFFFFFFFE, 32'h00000001);
    run(3'b100, 5, 0, 32'hFFFFFFFF);
    run(3'b111, 5, 0, 32'h00000005);
    run(3'b110, 32'hFFFFFFFB, 0, 32'hFFFFFFFB);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    run(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    // back-to-back without a gap
    issue(3'b101, 1000, 10, 32'd100);
    issue(3'b111, 1000, 9, 32'd1);
    finish_op();
    // ignored start mid-operation, then flush
    issue(3'b101, 100, 7, 32'h0000000E);
    repeat (4) @(negedge clk);
    start = 1;
    funct3 = 3'b100;
    dividend = 55;
    divisor = 5;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    flush = 1;
    sb.delete();
    @(negedge clk);
    flush = 0;
    check("flush_busy", {31'b0, busy}, 0);
    check("flush_done", {31'b0, done}, 0);
    // flush beats start in the same idle cycle
    start = 1;
    flush = 1;
    funct3 = 3'b101;
    dividend = 8;
    divisor = 2;
    @(negedge clk);
    start = 0;
    flush = 0;
    check("flush_start_busy", {31'b0, busy}, 0);
    run(3'b101, 9, 3, 32'h00000003);
    // reset mid-operation
    issue(3'b100, 1234567, 89, 32'd13871);
    repeat (19) @(negedge clk);
    rst = 1;
    sb.delete();
    @(negedge clk);
    rst = 0;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    check("midrst_result", result, 0);
    run(3'b101, 3, 10, 32'h00000000);
    run(3'b111, 3, 10, 32'h00000003);
    for (int i = 0; i < 60; i++) begin
      f = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        2: b = 0;
        3: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h1; end
        4: begin a = $urandom_range(0, 50); b = $urandom | 32'h100; end
        default: begin a = -$urandom_range(1, 5000); b = ($urandom_range(0, 1) != 0) ? -$urandom_range(1, 60) : $urandom_range(1, 60); end
      endcase
      run(f, a, b, model(f, a, b));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the EX stage of the RV32IM pipeline; executes div, divu, rem, remu, selected by muldiv funct3 (3'b100–3'b111).
- EX issues a start pulse with both operands and holds the pipeline on busy.
- The result is muxed onto the EX writeback path by the muldiv select when done is high.
- Multiply ops are handled elsewhere and never reach this block.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  3'b100 div, 3'b101 divu, 3'b110 rem, 3'b111 remu; sampled with start
dividend  input  WIDTH  rs1 value; sampled with start
divisor  input  WIDTH  rs2 value; sampled with start
flush  input  1  abandon current op (branch mispredict flush of EX)
busy  output  1  high in CALC and DONE; EX stalls while busy and not done
done  output  1  one-cycle result-valid strobe
result  output  WIDTH  quotient or remainder; valid while done, held until next accepted start

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0; internal quotient, remainder, counter and sign flags cleared. Reset mid-operation aborts with no done.
- States: IDLE, CALC, DONE. Outputs decode from registered state and data only; no combinational path from inputs to outputs.
- IDLE:
  - start=1 and flush=0 latches operands, funct3 and sign flags.
  - Signed ops (div, rem) take operand magnitudes; the quotient sign is dividend sign XOR divisor sign, and the remainder sign is the dividend sign.
  - Normal case: go to CALC with counter=WIDTH-1.
- Fast path, from IDLE directly to DONE with no CALC cycles:
  - divisor==0: quotient=all ones, remainder=dividend (signed and unsigned).
  - Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, signed op): quotient=0x80000000, remainder=0.
- CALC:
  - Each edge performs one restoring step: shift {rem,quot} left 1; if rem>=|divisor|, subtract and set quotient bit 0.
  - Width rules: the partial remainder is WIDTH+1 bits so the compare never overflows; the unsigned magnitude of 0x80000000 is 0x80000000.
  - Counter decrements each step. The step taken with counter==0 goes to DONE and registers the sign-corrected result: negate the quotient or remainder per the latched sign flags, signed ops only.
  - unsigned ops: no correction.
- Latency:
  - Start accepted at edge E0; done=1 in the cycle after edge E(WIDTH), so 32 cycles of busy-without-done and done in the 33rd cycle for WIDTH=32.
  - Fast path: done in the cycle after E0.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally back to IDLE. result keeps its value in IDLE until the next accepted start.
- start outside IDLE is ignored; no queueing. A start in the DONE cycle is also ignored, and EX re-issues it.
- flush=1 in any state returns to IDLE at the next edge with no done. flush and start in the same IDLE cycle: flush wins and nothing is accepted. flush in the DONE cycle still suppresses nothing: done is already asserted and EX discards it.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.

Optional Feature:
DIV_EARLY_OUT_EN:
- Defined: in IDLE, if |dividend| < |divisor| (divisor nonzero), take the fast path with quotient=0, remainder=dividend (original signed value); done in the cycle after E0.
- Undefined: no comparator; such operands go through the full WIDTH-step CALC with identical final results.
- Results are bit-identical either way; only latency differs.

Test Plan:
1. divu 100/7 -> result=0x0000000E, done exactly in the 33rd cycle after start edge, busy high all 33 cycles; remu 100/7 -> 0x00000002.
2. div 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; div 7/0xFFFFFFFE -> 0xFFFFFFFD; rem 7/-2 -> 0x00000001.
3. div 5/0 -> 0xFFFFFFFF with done in the cycle after start; remu 5/0 -> 0x00000005; rem 0xFFFFFFFB/0 -> 0xFFFFFFFB.
4. div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0x00000000, both fast-path; divu of the same operands -> 0x00000000 after full latency.
5. start divu 100/7; assert start with other operands at cycle 5 (ignored); flush at cycle 10 -> busy=0 next cycle, no done; new divu 9/3 -> 0x00000003 after full latency.
6. rst pulse at cycle 20 of a div -> busy=0, done=0, result=0 next cycle. With DIV_EARLY_OUT_EN, divu 3/10 -> 0x00000000 in 1 cycle and remu 3/10 -> 0x00000003; without it, the same values after 33 cycles.
